// File: rtl/nr_reciprocal_refine.sv
// nr_reciprocal_refine
// Sequential Newton-Raphson refinement of a seed reciprocal: x <- x*(2 - d*x).
// One multiplier is shared between the d*x and x*e steps, so each iteration
// costs two cycles. Valid/ready handshakes on both sides; result is registered.
module nr_reciprocal_refine #(
    parameter int SIZE  = 4,
    parameter int ITERS = 2,
    localparam int W    = 3*SIZE-3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] fraction,
    input  logic [W-1:0]    seed,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    recip
);

    // Product width covers the widest case: W-bit x times (W+1)-bit e.
    localparam int PW = 2*W+1;

    // Iteration count as a 4-bit compare value (0..15 supported).
    localparam logic [3:0] ITERS_C = 4'(ITERS);

    // 2.0 in Q2.(W-1), seen at product width and at error width.
    localparam logic [PW-1:0] TWO_P = {{W{1'b0}}, 1'b1, {W{1'b0}}};
    localparam logic [W:0]    TWO_E = {1'b1, {W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MUL_DX = 2'd1,
        MUL_XE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_r;
    logic [SIZE-1:0]   d_r;
    logic [W-1:0]      x_r;
    logic [W:0]        e_r;
    logic [3:0]        cnt_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [W-1:0]      recip_r;

    logic [PW-1:0]     op_a_s;
    logic [PW-1:0]     op_b_s;
    logic [PW-1:0]     prod_s;
    logic [PW-1:0]     p_wide_s;
    logic [PW-1:0]     t_wide_s;

    // e = 2.0 - p, clamped to zero when p has reached or passed 2.0.
    function automatic logic [W:0] clamp_err(input logic [PW-1:0] p);
        logic [W:0] res;
        if (p < TWO_P) begin
            res = TWO_E - p[W:0];
        end else begin
            res = {(W+1){1'b0}};
        end
        return res;
    endfunction

    // New x from t = x*e: saturate to all-ones when t is 2.0 or more.
    function automatic logic [W-1:0] sat_recip(input logic [PW-1:0] t);
        logic [W-1:0] res;
        if (t < TWO_P) begin
            res = t[W-1:0];
        end else begin
            res = {W{1'b1}};
        end
        return res;
    endfunction

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign recip     = recip_r;

    // Shared multiplier: x times d during MUL_DX, x times e otherwise.
    always_comb begin
        op_a_s = {{(W+1){1'b0}}, x_r};
        op_b_s = {PW{1'b0}};
        if (state_r == MUL_DX) begin
            op_b_s = {{(PW-SIZE){1'b0}}, d_r};
        end else begin
            op_b_s = {{W{1'b0}}, e_r};
        end
        prod_s   = op_a_s * op_b_s;
        p_wide_s = prod_s >> (SIZE-1);
        t_wide_s = prod_s >> (W-1);
    end

    // Control FSM with operand, error, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            d_r         <= {SIZE{1'b0}};
            x_r         <= {W{1'b0}};
            e_r         <= {(W+1){1'b0}};
            cnt_r       <= 4'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            recip_r     <= {W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        d_r        <= fraction;
                        x_r        <= seed;
                        cnt_r      <= 4'd0;
                        in_ready_r <= 1'b0;
                        if (ITERS_C == 4'd0) begin
                            state_r     <= DONE;
                            recip_r     <= seed;
                            out_valid_r <= 1'b1;
                        end else begin
                            state_r <= MUL_DX;
                        end
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                MUL_DX: begin
                    e_r     <= clamp_err(p_wide_s);
                    state_r <= MUL_XE;
                end
                MUL_XE: begin
                    x_r   <= sat_recip(t_wide_s);
                    cnt_r <= cnt_r + 4'd1;
                    if ((cnt_r + 4'd1) == ITERS_C) begin
                        state_r     <= DONE;
                        recip_r     <= sat_recip(t_wide_s);
                        out_valid_r <= 1'b1;
                    end else begin
                        state_r <= MUL_DX;
                    end
                end
                DONE: begin
                    // Incoming operands are ignored here; no same-cycle accept.
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nr_reciprocal_refine.sv
// Testbench for nr_reciprocal_refine (SIZE=4, W=9, 1.0 = 256).
// Three instances with ITERS = 0, 1, 2 share data inputs; each has its own
// in_valid. Results are checked against a plain-arithmetic reference model.
module tb_nr_reciprocal_refine;

    localparam int SIZE = 4;
    localparam int W    = 9;
    localparam int ONE  = 256;
    localparam int TWO  = 512;

    logic            clk;
    logic            rst_n;
    logic [SIZE-1:0] fraction;
    logic [W-1:0]    seed;
    logic            out_ready;

    logic            iv0, iv1, iv2;
    logic            rdy0, rdy1, rdy2;
    logic            ov0, ov1, ov2;
    logic [W-1:0]    rc0, rc1, rc2;

    int errors = 0;
    int checks = 0;

    int exp_q[$];

    nr_reciprocal_refine #(.SIZE(SIZE), .ITERS(0)) u_it0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(rdy0),
        .fraction(fraction), .seed(seed), .out_valid(ov0),
        .out_ready(out_ready), .recip(rc0)
    );

    nr_reciprocal_refine #(.SIZE(SIZE), .ITERS(1)) u_it1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(rdy1),
        .fraction(fraction), .seed(seed), .out_valid(ov1),
        .out_ready(out_ready), .recip(rc1)
    );

    nr_reciprocal_refine #(.SIZE(SIZE), .ITERS(2)) u_it2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(rdy2),
        .fraction(fraction), .seed(seed), .out_valid(ov2),
        .out_ready(out_ready), .recip(rc2)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Newton-Raphson in ordinary integers, truncating each step.
    function automatic int ref_recip(input int d, input int s, input int iters);
        int x, p, e, t;
        x = s;
        for (int i = 0; i < iters; i++) begin
            p = (d * x) / 8;
            e = (p < TWO) ? (TWO - p) : 0;
            t = (x * e) / ONE;
            x = (t >= TWO) ? (TWO - 1) : t;
        end
        return x;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic set_iv(input int inst, input logic v);
        case (inst)
            0:       iv0 = v;
            1:       iv1 = v;
            default: iv2 = v;
        endcase
    endtask

    function automatic logic get_ov(input int inst);
        case (inst)
            0:       return ov0;
            1:       return ov1;
            default: return ov2;
        endcase
    endfunction

    function automatic logic get_rdy(input int inst);
        case (inst)
            0:       return rdy0;
            1:       return rdy1;
            default: return rdy2;
        endcase
    endfunction

    function automatic logic [W-1:0] get_rc(input int inst);
        case (inst)
            0:       return rc0;
            1:       return rc1;
            default: return rc2;
        endcase
    endfunction

    // One transaction: accept, measure latency, check result, optionally release.
    task automatic run_op(input int inst, input int iters, input logic [SIZE-1:0] f,
                          input logic [W-1:0] s, input int expv, input bit release_out,
                          input string tag);
        int cyc;
        @(negedge clk);
        check({tag, "_in_ready"}, {31'd0, get_rdy(inst)}, 32'd1);
        fraction = f;
        seed     = s;
        set_iv(inst, 1'b1);
        @(negedge clk);
        set_iv(inst, 1'b0);
        cyc = 1;
        while (get_ov(inst) !== 1'b1 && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, 2*iters + 1);
        check({tag, "_recip"}, {23'd0, get_rc(inst)}, expv);
        if (release_out) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check({tag, "_ov_drop"}, {31'd0, get_ov(inst)}, 32'd0);
            check({tag, "_rdy_back"}, {31'd0, get_rdy(inst)}, 32'd1);
        end
    endtask

    initial begin
        int cyc, got, sent, stale, expv;
        logic [SIZE-1:0] pf;
        logic [W-1:0] ps;

        rst_n = 1'b0; fraction = '0; seed = '0; out_ready = 1'b0;
        iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ov", {31'd0, ov2}, 32'd0);
        check("reset_recip", {23'd0, rc2}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", {31'd0, rdy2}, 32'd1);

        // Directed points
        run_op(2, 2, 4'b1100, 9'd160, 170, 1'b1, "it2_1p5");
        run_op(1, 1, 4'b1000, 9'd256, 256, 1'b1, "it1_one");
        run_op(0, 0, 4'b1000, 9'd256, 256, 1'b1, "it0_one");
        run_op(1, 1, 4'b1111, 9'd511, 0, 1'b1, "it1_clamp");
        run_op(2, 2, 4'b1010, 9'd0, 0, 1'b1, "it2_seed0");

        // Back-pressure: result held while upstream keeps poking
        run_op(2, 2, 4'b1011, 9'd180, ref_recip(11, 180, 2), 1'b0, "bp_first");
        expv = ref_recip(11, 180, 2);
        for (int i = 0; i < 5; i++) begin
            iv2 = i[0];
            fraction = 4'(i + 9);
            seed = 9'(i * 37);
            @(negedge clk);
            check("bp_ov_hold", {31'd0, ov2}, 32'd1);
            check("bp_recip_hold", {23'd0, rc2}, expv);
            check("bp_in_ready_low", {31'd0, rdy2}, 32'd0);
        end
        iv2 = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_ov", {31'd0, ov2}, 32'd0);
        check("bp_release_rdy", {31'd0, rdy2}, 32'd1);
        run_op(2, 2, 4'b1101, 9'd200, ref_recip(13, 200, 2), 1'b1, "bp_second");

        // Reset during the second MUL_DX
        @(negedge clk);
        fraction = 4'b1100; seed = 9'd160; iv2 = 1'b1;
        @(negedge clk);
        iv2 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ov", {31'd0, ov2}, 32'd0);
        check("rst_mid_recip", {23'd0, rc2}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_rdy", {31'd0, rdy2}, 32'd1);
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ov2 !== 1'b0) stale++;
        end
        check("rst_no_stale", stale, 32'd0);
        run_op(2, 2, 4'b1001, 9'd230, ref_recip(9, 230, 2), 1'b1, "rst_recover");

        // Random back-to-back traffic with random handshakes
        pf = 4'($urandom); ps = 9'($urandom);
        sent = 0; got = 0; cyc = 0;
        while (got < 200 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 1) == 1);
            if (ov2 === 1'b1 && out_ready) begin
                if (exp_q.size() > 0) begin
                    check("rand_recip", {23'd0, rc2}, exp_q.pop_front());
                end else begin
                    check("rand_extra_result", 32'd1, 32'd0);
                end
                got++;
            end
            iv2 = (sent < 200) && ($urandom_range(0, 1) == 1);
            fraction = pf;
            seed = ps;
            if (iv2 && rdy2 === 1'b1) begin
                exp_q.push_back(ref_recip(int'(pf), int'(ps), 2));
                sent++;
                pf = 4'($urandom);
                ps = 9'($urandom);
            end
        end
        @(negedge clk);
        iv2 = 1'b0;
        out_ready = 1'b0;
        check("rand_count", got, 32'd200);
        check("rand_queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
